key_stream_tx: RTL and testbench
================================

Name: key_stream_tx

Overview:
- Transmit side of the round-key transfer.
- Accepts one parallel bundle of ROUND round keys through a valid/ready handshake.
- Emits the keys serially, one KEY_SIZE word per beat, on a tvalid/tready/tlast stream, in order K0 first.
- Sits between the key source (seed/chaos key generator) and the key collector that rebuilds the parallel round-key set for the cipher rounds.

Parameters:
- ROUND, 5, number of round keys per bundle (2..7).
- KEY_SIZE, 128, width of one round key in bits.
- CNT_W, 3, width of the beat index counter; must satisfy 2**CNT_W > ROUND.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bundle on keys_flat is valid.
- in_ready  output  1  block can accept a bundle.
- keys_flat  input  ROUND*KEY_SIZE  packed keys; K0 at [KEY_SIZE-1:0], Ki at [(i+1)*KEY_SIZE-1 : i*KEY_SIZE].
- tvalid  output  1  stream beat valid.
- tready  input  1  downstream accepts beat.
- tdata  output  KEY_SIZE  current key word.
- tlast  output  1  final beat of bundle.
- busy  output  1  high while in SEND.
- done  output  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Reset, asynchronous active-low:
  - State returns to IDLE; key registers and index are cleared to 0.
  - Outputs: tvalid=0, tdata=0, tlast=0, busy=0, done=0, in_ready=1 after release.
- Reset asserted mid-bundle aborts the transfer with no further beats. There is no resume.
- FSM states: IDLE and SEND.
- IDLE:
  - in_ready=1 (combinational from state); tvalid=0.
  - On in_valid && in_ready: capture all ROUND keys, clear index to 0, go to SEND.
  - The first beat is presented the next cycle, so input-to-first-beat latency is 1 cycle.
- SEND:
  - in_ready=0, and in_valid is ignored.
  - tvalid=1, busy=1, tdata=K[index], tlast=(index==ROUND-1).
  - On tvalid && tready with index<ROUND-1: index increments.
  - On tvalid && tready with index==ROUND-1: go to IDLE, pulse done next cycle, deassert tvalid and tlast.
- Stall: while tvalid && !tready, tdata, tlast and index hold stable. tvalid never drops before its handshake.
- Throughput:
  - With tready held high, beats go out on ROUND consecutive cycles.
  - One IDLE cycle follows before the next bundle can be accepted.
  - Full period is ROUND+1 cycles per bundle.
- tready is allowed to be tied high by a collector that only counts valid beats.
- The index never exceeds ROUND-1; no wrap-around into stale registers.
- tdata drives 0 whenever tvalid=0.
- Captured keys are registered, so changes on keys_flat during SEND have no effect.

Optional Feature:
- Macro: KEY_TX_CHECKSUM_EN.
- Defined:
  - One extra beat follows the ROUND keys; tdata on that beat is the XOR of all ROUND captured keys.
  - tlast moves to the checksum beat; the index runs 0..ROUND.
  - done fires after the checksum beat.
  - The bundle period becomes ROUND+2 cycles.
- Undefined: behaviour exactly as described above, with no extra beat or logic.

Decomposition:
- Shared package key_pkg:
  - ROUND and KEY_SIZE defaults.
  - CNT_W derived constant.
  - tx state enum (IDLE, SEND).
  - Function key_xor_fold(keys_flat) for the checksum.
- No sub-module is needed; the FSM, key register file and index counter live in one module.
- The checksum fold is a package function, not a separate instance.

Test Plan:
- Reset, then bundle K0..K4 = 0x11..11, 0x22..22, 0x33..33, 0x44..44, 0x55..55 with tready=1:
  - Beats appear on cycles 1-5 after capture with tdata in that order.
  - tlast is high only on the 0x55..55 beat.
  - done pulses on cycle 6; in_ready returns to 1 on cycle 6.
- Same bundle, tready low for 3 cycles during beat 2:
  - tdata holds 0x33..33 with tvalid=1 throughout the stall; no beat is lost or duplicated.
- in_valid pulsed during SEND with a different bundle:
  - in_ready=0 and the new bundle is ignored; the stream still carries the first bundle.
- reset_n asserted after beat 2 handshakes:
  - tvalid=0 and busy=0 immediately; after release in_ready=1 and a new bundle streams from K0.
- Two back-to-back bundles with in_valid held high:
  - The second is accepted in the IDLE cycle after done; period is 6 cycles.
- With KEY_TX_CHECKSUM_EN and keys 0x01, 0x02, 0x04, 0x08, 0x10 (zero-extended):
  - Sixth beat has tdata=0x1F and tlast=1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants, FSM state type and checksum fold for the round-key stream transmitter.
package key_pkg;

  localparam int DEF_ROUND    = 5;
  localparam int DEF_KEY_SIZE = 128;
  localparam int DEF_CNT_W    = $clog2(DEF_ROUND + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  function automatic logic [DEF_KEY_SIZE-1:0] key_xor_fold(
    input logic [DEF_ROUND*DEF_KEY_SIZE-1:0] keys_flat
  );
    logic [DEF_KEY_SIZE-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEF_ROUND; i++) begin
      acc = acc ^ keys_flat[i*DEF_KEY_SIZE +: DEF_KEY_SIZE];
    end
    return acc;
  endfunction

endpackage

// File: rtl/key_stream_tx.sv
// Captures a parallel round-key bundle and streams it K0-first on tvalid/tready/tlast.
// Optional macro KEY_TX_CHECKSUM_EN appends an XOR-of-all-keys beat after the last key.
module key_stream_tx
  import key_pkg::*;
#(
  parameter int ROUND    = DEF_ROUND,
  parameter int KEY_SIZE = DEF_KEY_SIZE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROUND*KEY_SIZE-1:0] keys_flat,
  output logic                      tvalid,
  input  logic                      tready,
  output logic [KEY_SIZE-1:0]       tdata,
  output logic                      tlast,
  output logic                      busy,
  output logic                      done
);

`ifdef KEY_TX_CHECKSUM_EN
  localparam int LAST = ROUND;
`else
  localparam int LAST = ROUND - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST);

  tx_state_t           state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d, idx_inc;
  logic [KEY_SIZE-1:0] keys_q [ROUND];
  logic [KEY_SIZE-1:0] keys_d [ROUND];
  logic [KEY_SIZE-1:0] in_words [ROUND];
  logic [KEY_SIZE-1:0] tdata_q, tdata_d, next_word;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef KEY_TX_CHECKSUM_EN
  logic [KEY_SIZE-1:0] csum_q, csum_d;
`endif

  generate
    for (genvar gi = 0; gi < ROUND; gi++) begin : g_unpack
      assign in_words[gi] = keys_flat[gi*KEY_SIZE +: KEY_SIZE];
    end
  endgenerate

  assign idx_inc = idx_q + 1'b1;

  // Word for the following beat; the explicit compare keeps stale slots unreachable.
  always_comb begin
    next_word = '0;
    for (int i = 0; i < ROUND; i++) begin
      if (idx_inc == CNT_W'(i)) next_word = keys_q[i];
    end
`ifdef KEY_TX_CHECKSUM_EN
    if (idx_inc == LAST_IDX) next_word = csum_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    keys_d   = keys_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef KEY_TX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          keys_d   = in_words;
`ifdef KEY_TX_CHECKSUM_EN
          csum_d   = key_xor_fold(keys_flat);
`endif
          idx_d    = '0;
          state_d  = SEND;
          tvalid_d = 1'b1;
          busy_d   = 1'b1;
          tdata_d  = in_words[0];
          tlast_d  = (LAST_IDX == '0);
        end
      end
      SEND: begin
        if (tready) begin
          if (idx_q == LAST_IDX) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            idx_d   = idx_inc;
            tdata_d = next_word;
            tlast_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      keys_q   <= '{default: '0};
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef KEY_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      keys_q   <= keys_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef KEY_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign tvalid   = tvalid_q;
  assign tdata    = tdata_q;
  assign tlast    = tlast_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_stream_tx.sv
// Scoreboard bench for key_stream_tx: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_key_stream_tx;

  localparam int ROUND    = 5;
  localparam int KEY_SIZE = 128;
  localparam int CNT_W    = 3;
`ifdef KEY_TX_CHECKSUM_EN
  localparam int NB   = ROUND + 1;
  localparam bit CSUM = 1'b1;
`else
  localparam int NB   = ROUND;
  localparam bit CSUM = 1'b0;
`endif

  logic                      clk;
  logic                      reset_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROUND*KEY_SIZE-1:0] keys_flat;
  logic                      tvalid;
  logic                      tready;
  logic [KEY_SIZE-1:0]       tdata;
  logic                      tlast;
  logic                      busy;
  logic                      done;

  key_stream_tx #(
    .ROUND   (ROUND),
    .KEY_SIZE(KEY_SIZE),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .keys_flat(keys_flat),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tlast    (tlast),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [KEY_SIZE-1:0] d;
    logic                l;
  } beat_t;

  beat_t               exp_q[$];
  beat_t               mon_e;
  int                  checks   = 0;
  int                  failures = 0;
  logic [KEY_SIZE-1:0] kv [ROUND];

  // Byte patterns: A = 11..55, B = A0..A4, C = C1..C5, D = single-bit keys.
  logic [7:0] pat [4][ROUND] = '{
    '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55},
    '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4},
    '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5},
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [KEY_SIZE-1:0] act, input logic [KEY_SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_keys(input int p, input bit rep);
    for (int i = 0; i < ROUND; i++) begin
      kv[i] = rep ? {16{pat[p][i]}} : {120'd0, pat[p][i]};
      keys_flat[i*KEY_SIZE +: KEY_SIZE] = kv[i];
    end
  endtask

  task automatic expect_beats(input int n);
    logic [KEY_SIZE-1:0] x;
    beat_t b;
    x = '0;
    for (int i = 0; i < ROUND; i++) begin
      x = x ^ kv[i];
      if (i < n) begin
        b.d = kv[i];
        b.l = (i == ROUND - 1) && !CSUM;
        exp_q.push_back(b);
      end
    end
    if (CSUM && n == ROUND) begin
      b.d = x;
      b.l = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic offer();
    @(negedge clk);
    chk("offer_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected: got tdata %h tlast %b expected no beat", tdata, tlast);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_tdata", tdata, mon_e.d);
        chk("beat_tlast", tlast, mon_e.l);
      end
    end
    if (reset_n && !tvalid) begin
      chk("idle_tdata_zero", tdata, '0);
      chk("idle_tlast_zero", tlast, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    tready    = 1'b1;
    keys_flat = '0;
    #1;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_tvalid", tvalid, 1'b0);
    chk("rel_tdata", tdata, '0);
    chk("rel_tlast", tlast, 1'b0);
    chk("rel_busy", busy, 1'b0);
    chk("rel_done", done, 1'b0);

    // Full-rate bundle: beats on cycles 1..NB, done and in_ready on NB+1.
    set_keys(0, 1'b1);
    expect_beats(ROUND);
    offer();
    for (int c = 1; c <= NB + 1; c++) begin
      @(negedge clk);
      chk("t1_tvalid", tvalid, c <= NB);
      chk("t1_busy", busy, c <= NB);
      chk("t1_done", done, c == NB + 1);
      chk("t1_in_ready", in_ready, c == NB + 1);
    end

    // Three-cycle stall while K2 is presented.
    set_keys(0, 1'b1);
    expect_beats(ROUND);
    offer();
    @(posedge clk);
    @(posedge clk);
    #1 tready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_tvalid", tvalid, 1'b1);
      chk("t2_stall_tdata", tdata, {16{8'h33}});
      chk("t2_stall_tlast", tlast, 1'b0);
    end
    @(posedge clk);
    #1 tready = 1'b1;
    wait_done("t2_done");

    // New bundle offered during SEND is ignored; stream keeps bundle A.
    set_keys(0, 1'b1);
    expect_beats(ROUND);
    offer();
    set_keys(1, 1'b1);
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t3_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    wait_done("t3_done");
    repeat (2) begin
      @(negedge clk);
      chk("t3_no_accept", tvalid, 1'b0);
    end

    // Reset after the second beat handshakes aborts the bundle.
    set_keys(2, 1'b1);
    expect_beats(2);
    offer();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t4_rst_tvalid", tvalid, 1'b0);
    chk("t4_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t4_rel_in_ready", in_ready, 1'b1);
    set_keys(1, 1'b1);
    expect_beats(ROUND);
    offer();
    wait_done("t4_done");

    // Back-to-back bundles with in_valid held high: period NB+1.
    set_keys(0, 1'b1);
    expect_beats(ROUND);
    expect_beats(ROUND);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2 * (NB + 1); c++) begin
      @(negedge clk);
      chk("t5_tvalid", tvalid, (c % (NB + 1)) != 0);
      chk("t5_done", done, (c % (NB + 1)) == 0);
      if (c == NB + 2) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("t5_end_tvalid", tvalid, 1'b0);

    // Single-bit keys; with the checksum enabled the last beat carries 0x1F.
    set_keys(3, 1'b0);
    expect_beats(ROUND);
    offer();
    for (int c = 1; c <= NB; c++) @(negedge clk);
    chk("t6_last_tlast", tlast, 1'b1);
`ifdef KEY_TX_CHECKSUM_EN
    chk("t6_csum_tdata", tdata, 128'h1F);
`else
    chk("t6_last_tdata", tdata, 128'h10);
`endif
    wait_done("t6_done");

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
